noise_env_len: RTL



---
 rtl/noise_env_len.sv | 139 +++++++++++++
 1 files changed

// File: rtl/noise_env_len.sv
// Noise channel envelope generator and length counter.
// Decodes $400C/$400F writes and produces the registered volume and the length-active status.
module noise_env_len #(
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [1:0]       wr_addr,
    input  logic [7:0]       wr_data,
    input  logic             quarter_tick,
    input  logic             half_tick,
    input  logic             chan_en,
    input  logic             lfsr_bit,
    output logic [3:0]       vol_out,
    output logic             len_active
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] DECAY_MAX = CNT_W'(15);

    logic             halt_q,  halt_d;
    logic             const_q, const_d;
    logic [CNT_W-1:0] n_q,     n_d;
    logic             start_q, start_d;
    logic [CNT_W-1:0] decay_q, decay_d;
    logic [CNT_W-1:0] div_q,   div_d;
    logic [LEN_W-1:0] len_q,   len_d;
    logic [CNT_W-1:0] vol_q,   vol_d;
    logic             act_q,   act_d;

    // Length load values indexed by $400F data[7:3].
    function automatic logic [LEN_W-1:0] len_lookup(input logic [4:0] idx);
        logic [7:0] v;
        case (idx)
            5'd0:  v = 8'd10;   5'd1:  v = 8'd254;
            5'd2:  v = 8'd20;   5'd3:  v = 8'd2;
            5'd4:  v = 8'd40;   5'd5:  v = 8'd4;
            5'd6:  v = 8'd80;   5'd7:  v = 8'd6;
            5'd8:  v = 8'd160;  5'd9:  v = 8'd8;
            5'd10: v = 8'd60;   5'd11: v = 8'd10;
            5'd12: v = 8'd14;   5'd13: v = 8'd12;
            5'd14: v = 8'd26;   5'd15: v = 8'd14;
            5'd16: v = 8'd12;   5'd17: v = 8'd16;
            5'd18: v = 8'd24;   5'd19: v = 8'd18;
            5'd20: v = 8'd48;   5'd21: v = 8'd20;
            5'd22: v = 8'd96;   5'd23: v = 8'd22;
            5'd24: v = 8'd192;  5'd25: v = 8'd24;
            5'd26: v = 8'd72;   5'd27: v = 8'd26;
            5'd28: v = 8'd16;   5'd29: v = 8'd28;
            5'd30: v = 8'd32;   default: v = 8'd30;
        endcase
        return LEN_W'(v);
    endfunction

    always_comb begin
        halt_d  = halt_q;
        const_d = const_q;
        n_d     = n_q;
        start_d = start_q;
        decay_d = decay_q;
        div_d   = div_q;
        len_d   = len_q;

        // Envelope step sees the pre-write start flag; a same-cycle $400F write re-arms it below.
        if (quarter_tick) begin
            if (start_q) begin
                start_d = 1'b0;
                decay_d = DECAY_MAX;
                div_d   = n_q;
            end else if (div_q == '0) begin
                div_d = n_q;
                if (decay_q != '0) begin
                    decay_d = decay_q - CNT_W'(1);
                end else if (halt_q) begin
                    decay_d = DECAY_MAX;
                end
            end else begin
                div_d = div_q - CNT_W'(1);
            end
        end

        if (half_tick && !halt_q && (len_q != '0)) begin
            len_d = len_q - LEN_W'(1);
        end

        if (wr_en) begin
            case (wr_addr)
                2'd0: begin
                    halt_d  = wr_data[5];
                    const_d = wr_data[4];
                    n_d     = wr_data[3:0];
                end
                2'd3: begin
                    start_d = 1'b1;
                    if (chan_en) begin
                        len_d = len_lookup(wr_data[7:3]);
                    end
                end
                default: ;
            endcase
        end

        if (!chan_en) begin
            len_d = '0;
        end

        vol_d = ((len_q == '0) || lfsr_bit) ? '0 : (const_q ? n_q : decay_q);
        act_d = (len_q != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halt_q  <= 1'b0;
            const_q <= 1'b0;
            n_q     <= '0;
            start_q <= 1'b0;
            decay_q <= '0;
            div_q   <= '0;
            len_q   <= '0;
            vol_q   <= '0;
            act_q   <= 1'b0;
        end else begin
            halt_q  <= halt_d;
            const_q <= const_d;
            n_q     <= n_d;
            start_q <= start_d;
            decay_q <= decay_d;
            div_q   <= div_d;
            len_q   <= len_d;
            vol_q   <= vol_d;
            act_q   <= act_d;
        end
    end

    assign vol_out    = vol_q;
    assign len_active = act_q;

endmodule
